// File: rtl/plu_controller.sv
// PLU sequencer: accepts a job, steps the MUL/ADD/RELU register enables and presents the result;
// out_valid follows the accept edge by 4 cycles, and while out_ready is low the result holds with every enable low.
module plu_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             w_we,
    output logic             a_we,
    output logic             r1_we,
    output logic             r2_we,
    output logic             r3_we,
    input  logic             overflow,
    output logic             ovf_flag,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);
    typedef enum logic [2:0] {IDLE, MUL, ADD, RELU, DONE} state_t;

    state_t state;
    logic   acc;
    logic   consume;

    // A new job may enter in the same cycle the previous result is taken.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign acc      = in_valid & in_ready;
    assign consume  = out_valid & out_ready;
    assign w_we     = acc;
    assign a_we     = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r1_we     <= 1'b0;
            r2_we     <= 1'b0;
            r3_we     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            ovf_flag  <= 1'b0;
            job_count <= '0;
        end else begin
            r1_we <= 1'b0;
            r2_we <= 1'b0;
            r3_we <= 1'b0;

            if (consume)
                job_count <= job_count + CNT_W'(1);

            // Stale stage contents may also raise overflow; that only errs towards flagging.
            if (acc)
                ovf_flag <= 1'b0;
            else if (state inside {MUL, ADD, RELU})
                ovf_flag <= ovf_flag | overflow;

            case (state)
                IDLE: begin
                    if (acc) begin
                        state <= MUL;
                        r1_we <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    state <= ADD;
                    r2_we <= 1'b1;
                end
                ADD: begin
                    state <= RELU;
                    r3_we <= 1'b1;
                end
                RELU: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (acc) begin
                            state <= MUL;
                            r1_we <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plu_controller.sv
// Bench for plu_controller: a stand-in PLU datapath driven by the controller's enables,
// plus a cycles-since-accept reference model for handshake, enables, result and overflow.
module tb_plu_controller;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid;
    logic             w_we, a_we, r1_we, r2_we, r3_we;
    logic             overflow, ovf_flag, busy;
    logic [CNT_W-1:0] job_count;

    always #5 clk = ~clk;

    plu_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .w_we(w_we), .a_we(a_we), .r1_we(r1_we), .r2_we(r2_we), .r3_we(r3_we),
        .overflow(overflow), .ovf_flag(ovf_flag), .busy(busy), .job_count(job_count)
    );

    // Stand-in datapath: 4 lanes of 32-bit signed multiply, sum, ReLU.
    logic signed [31:0] w_in [4];
    logic signed [31:0] a_in [4];
    logic signed [31:0] w_r [4];
    logic signed [31:0] a_r [4];
    logic signed [31:0] p_r [4];
    logic signed [31:0] s_r, out_r;

    function automatic logic fits(input longint v);
        return (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                w_r[i] <= '0; a_r[i] <= '0; p_r[i] <= '0;
            end
            s_r   <= '0;
            out_r <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_we)  w_r[i] <= w_in[i];
                if (a_we)  a_r[i] <= a_in[i];
                if (r1_we) p_r[i] <= w_r[i] * a_r[i];
            end
            if (r2_we) s_r <= p_r[0] + p_r[1] + p_r[2] + p_r[3];
            if (r3_we) out_r <= s_r[31] ? 32'sd0 : s_r;
        end
    end

    always_comb begin
        overflow = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!fits(longint'(w_r[i]) * longint'(a_r[i]))) overflow = 1'b1;
        if (!fits(longint'(p_r[0]) + longint'(p_r[1]) + longint'(p_r[2]) + longint'(p_r[3])))
            overflow = 1'b1;
    end

    // Reference model state
    int                 tests = 0;
    int                 fails = 0;
    int                 t = -1;        // cycles since the in-flight job was accepted, -1 when none
    int                 exp_count = 0;
    logic signed [31:0] exp_out;
    logic               exp_ovf;
    logic               exp_rdy;
    logic [7:0]         exp_vec, obs_vec;

    task automatic calc_expect();
        longint s = 0;
        longint p;
        exp_ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p = longint'(w_in[i]) * longint'(a_in[i]);
            if (!fits(p)) exp_ovf = 1'b1;
            s += longint'(int'(p));
        end
        if (!fits(s)) exp_ovf = 1'b1;
        exp_out = (int'(s) < 0) ? 32'sd0 : int'(s);
    endtask

    task automatic sample(input logic iv, input logic ordy);
        in_valid  = iv;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (t < 0) || (t >= 4 && ordy);
        exp_vec = {exp_rdy, iv & exp_rdy, iv & exp_rdy, t == 1, t == 2, t == 3, t >= 4, t >= 1};
        obs_vec = {in_ready, w_we, a_we, r1_we, r2_we, r3_we, out_valid, busy};
    endtask

    task automatic tick();
        logic acc, done;
        acc  = in_valid && exp_rdy;
        done = (t >= 4) && out_ready;
        @(posedge clk);
        if (done) exp_count++;
        if (acc) begin
            t = 1;
            calc_expect();
        end else if (done) begin
            t = -1;
        end else if (t >= 1 && t < 4) begin
            t++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; t = -1; exp_count = 0;
    endtask

    task automatic set_ops(input int w0, w1, w2, w3, a0, a1, a2, a3);
        w_in[0] = w0; w_in[1] = w1; w_in[2] = w2; w_in[3] = w3;
        a_in[0] = a0; a_in[1] = a1; a_in[2] = a2; a_in[3] = a3;
    endtask

    task automatic test_reset();
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs_vec = {in_ready, w_we, a_we, r1_we, r2_we, r3_we, out_valid, busy};
        tests++;
        if (obs_vec !== 8'b1000_0000) begin
            fails++; $display("FAIL reset outputs: got %b want %b", obs_vec, 8'b1000_0000);
        end
        tests++;
        if (ovf_flag !== 1'b0) begin
            fails++; $display("FAIL reset ovf_flag: got %b want 0", ovf_flag);
        end
        tests++;
        if (job_count !== '0) begin
            fails++; $display("FAIL reset job_count: got %0d want 0", job_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int tw[4][4];
        int ta[4][4];
        int tout[4];
        logic tovf[4];
        tw[0] = '{1, 2, 3, 4};         ta[0] = '{5, 6, 7, 8};         tout[0] = 70; tovf[0] = 1'b0;
        tw[1] = '{-1, -1, -1, -1};     ta[1] = '{2, 2, 2, 2};         tout[1] = 0;  tovf[1] = 1'b0;
        tw[2] = '{32'h10000, 2, 3, 4}; ta[2] = '{32'h10000, 1, 1, 1}; tout[2] = 9;  tovf[2] = 1'b1;
        tw[3] = '{1, 1, 1, 1};         ta[3] = '{1, 2, 3, 4};         tout[3] = 10; tovf[3] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            set_ops(tw[j][0], tw[j][1], tw[j][2], tw[j][3], ta[j][0], ta[j][1], ta[j][2], ta[j][3]);
            for (int c = 0; c <= 4; c++) begin
                sample(c == 0, 1'b1);
                tests++;
                if (obs_vec !== exp_vec) begin
                    fails++; $display("FAIL directed job %0d cycle %0d enables: got %b want %b", j, c, obs_vec, exp_vec);
                end
                if (c == 1) begin
                    tests++;
                    if (ovf_flag !== 1'b0) begin
                        fails++; $display("FAIL directed job %0d ovf cleared on accept: got %b want 0", j, ovf_flag);
                    end
                end
                if (c == 4) begin
                    tests++;
                    if (out_r !== tout[j]) begin
                        fails++; $display("FAIL directed job %0d result: got %0d want %0d", j, out_r, tout[j]);
                    end
                    tests++;
                    if (ovf_flag !== tovf[j]) begin
                        fails++; $display("FAIL directed job %0d ovf_flag: got %b want %b", j, ovf_flag, tovf[j]);
                    end
                end
                tick();
            end
        end
        tests++;
        if (job_count !== CNT_W'(exp_count)) begin
            fails++; $display("FAIL directed job_count: got %0d want %0d", job_count, exp_count);
        end
    endtask

    task automatic test_hold();
        set_ops(32'h10000, 2, 3, 4, 32'h10000, 1, 1, 1);
        for (int c = 0; c < 4; c++) begin
            sample(c == 0, 1'b1);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL hold fill cycle %0d: got %b want %b", c, obs_vec, exp_vec);
            end
            tick();
        end
        set_ops(1, 1, 1, 1, 1, 1, 1, 1);
        for (int h = 0; h < 5; h++) begin
            sample(1'b1, 1'b0);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL hold stall %0d enables: got %b want %b", h, obs_vec, exp_vec);
            end
            tests++;
            if (out_r !== 32'sd9 || ovf_flag !== 1'b1) begin
                fails++; $display("FAIL hold stall %0d data: got out=%0d ovf=%b want out=9 ovf=1", h, out_r, ovf_flag);
            end
            tick();
        end
        for (int c = 0; c <= 4; c++) begin
            sample(c == 0, 1'b1);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL hold release cycle %0d: got %b want %b", c, obs_vec, exp_vec);
            end
            if (c == 4) begin
                tests++;
                if (out_r !== 32'sd4 || ovf_flag !== 1'b0) begin
                    fails++; $display("FAIL hold follow-on data: got out=%0d ovf=%b want out=4 ovf=0", out_r, ovf_flag);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc[$];
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            if (c == 0 || c == 4 || c == 8)
                set_ops(c + 1, c + 2, -3, 4, 5, c, 7, -c - 1);
            sample(c <= 8, 1'b1);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL b2b cycle %0d enables: got %b want %b", c, obs_vec, exp_vec);
            end
            if (out_valid === 1'b1) begin
                done_cyc.push_back(c);
                tests++;
                if (out_r !== exp_out || ovf_flag !== exp_ovf) begin
                    fails++; $display("FAIL b2b cycle %0d data: got out=%0d ovf=%b want out=%0d ovf=%b", c, out_r, ovf_flag, exp_out, exp_ovf);
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (done_cyc.size() <= k || done_cyc[k] != 4 * (k + 1)) begin
                fails++; $display("FAIL b2b result %0d cycle: got %0d want %0d", k, (done_cyc.size() > k) ? done_cyc[k] : -1, 4 * (k + 1));
            end
        end
        tests++;
        if (job_count !== CNT_W'(3)) begin
            fails++; $display("FAIL b2b job_count: got %0d want 3", job_count);
        end
    endtask

    task automatic test_reset_mid_job();
        do_reset();
        set_ops(3, 3, 3, 3, 2, 2, 2, 2);
        for (int c = 0; c <= 2; c++) begin
            sample(c == 0, 1'b1);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL midreset cycle %0d enables: got %b want %b", c, obs_vec, exp_vec);
            end
            if (c < 2) tick();
        end
        rst = 1'b1;
        #1;
        obs_vec = {in_ready, w_we, a_we, r1_we, r2_we, r3_we, out_valid, busy};
        tests++;
        if (obs_vec !== 8'b1000_0000) begin
            fails++; $display("FAIL midreset immediate outputs: got %b want %b", obs_vec, 8'b1000_0000);
        end
        tests++;
        if (job_count !== '0) begin
            fails++; $display("FAIL midreset job_count: got %0d want 0", job_count);
        end
        @(posedge clk); #1;
        rst = 1'b0; t = -1; exp_count = 0;
        sample(1'b0, 1'b0);
        tests++;
        if (obs_vec !== exp_vec) begin
            fails++; $display("FAIL midreset idle after release: got %b want %b", obs_vec, exp_vec);
        end
        tick();
    endtask

    task automatic test_random();
        logic pending = 1'b0;
        logic acc;
        for (int c = 0; c < 400; c++) begin
            if (!pending && $urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    w_in[i] = int'($urandom_range(2000, 0)) - 1000;
                    a_in[i] = int'($urandom_range(2000, 0)) - 1000;
                end
                if ($urandom_range(7, 0) == 0) begin
                    w_in[0] = 32'sh10000;
                    a_in[0] = 32'sh10000;
                end
                pending = 1'b1;
            end
            sample(pending, $urandom_range(9, 0) < 7);
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++; $display("FAIL random cycle %0d enables: got %b want %b", c, obs_vec, exp_vec);
            end
            if (t >= 4) begin
                tests++;
                if (out_r !== exp_out || ovf_flag !== exp_ovf) begin
                    fails++; $display("FAIL random cycle %0d data: got out=%0d ovf=%b want out=%0d ovf=%b", c, out_r, ovf_flag, exp_out, exp_ovf);
                end
            end
            acc = pending && exp_rdy;
            tick();
            if (acc) pending = 1'b0;
        end
        tests++;
        if (job_count !== CNT_W'(exp_count)) begin
            fails++; $display("FAIL random job_count: got %0d want %0d", job_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
